dma_cmd_arbiter: RTL and testbench
==================================

// Module: dma_cmd_arbiter
// PURPOSE
// Round-robin arbiter/sequencer sharing the single DMAC command port among NUM_REQ requesters.
// Grants one requester, captures its command, and presents it on cmd_* until the DMAC accepts or aborts it.
// A watchdog drops a command the DMAC never accepts. Results return to the originator as one-cycle pulses.
// Sits between requester engines and DMAC; cmd_id carries the granted requester index.
// PARAMETERS
// NUM_REQ      4   number of requesters (2..16)
// AXI_ID_WD    2   width of cmd_id; must be >= clog2(NUM_REQ)
// AXI_ADDR_WD  32  width of addr and len fields
// TIMEOUT      256 cycles in ISSUE before the command is dropped; 0 disables the watchdog
// PORTS
// AXI_ACLK     in  1              clock
// AXI_ARESET   in  1              async reset, active-high
// req_valid    in  NUM_REQ        per-requester command valid
// req_addr     in  NUM_REQ*ADDR   packed start addresses, requester i at [i*ADDR +: ADDR]
// req_burst    in  NUM_REQ*2      packed AXI burst types
// req_size     in  NUM_REQ*3      packed AXI sizes
// req_len      in  NUM_REQ*ADDR   packed transfer lengths
// req_ready    out NUM_REQ        one-hot grant/capture strobe (combinational)
// req_done     out NUM_REQ        pulse: DMAC accepted requester i's command
// req_abort    out NUM_REQ        pulse: DMAC aborted requester i's command
// req_timeout  out NUM_REQ        pulse: watchdog dropped requester i's command
// cmd_valid    out 1              to DMAC, registered
// cmd_addr     out ADDR           registered copy of the granted req_addr
// cmd_id       out AXI_ID_WD      granted index, zero-extended
// cmd_burst    out 2              registered
// cmd_size     out 3              registered
// cmd_len      out ADDR           registered
// cmd_ready    in  1              DMAC accept
// cmd_abort    in  1              DMAC abort
// BEHAVIOUR
// Reset (async): state=IDLE, rr_ptr=0, wdog=0, all cmd_* = 0, all req_* outputs = 0.
// FSM: IDLE -> ISSUE -> GAP -> IDLE.
// - IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready[winner]=1 combinationally, only in IDLE. On that edge: capture fields, cmd_id=winner, go to ISSUE.
//   No req_valid: stay in IDLE, req_ready=0.
// - ISSUE: cmd_valid=1 and cmd_* held stable. wdog increments every cycle from 0. Per cycle, priority:
//   1) cmd_abort=1 -> pulse req_abort[g], go to GAP.
//   2) cmd_ready=1 -> pulse req_done[g], go to GAP.
//   3) TIMEOUT!=0 and wdog==TIMEOUT-1 -> pulse req_timeout[g], go to GAP.
//   Abort and ready in the same cycle reports abort only. Ready on the final watchdog cycle reports done.
// - GAP: cmd_valid=0, wdog=0, rr_ptr=(g+1) mod NUM_REQ, then IDLE. Guarantees one idle cycle between commands.
// - Result pulses are registered and high only during the GAP cycle. Exactly one of done/abort/timeout fires per grant.
// - Latency: req_valid in IDLE at cycle 0; cmd_valid at cycle 1; earliest next grant 2 cycles after acceptance.
// - Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
// - Requester drops or changes req_valid after its req_ready: no effect on the captured command.
// - Reset mid-ISSUE: cmd_valid drops immediately with no result pulse; requesters must re-request.
// - cmd_* fields keep their last values while cmd_valid=0. Only cmd_valid is qualifying.
// TESTING
// T1 single: req_valid=0001, addr=0x1000, len=64, ready at cycle 3 -> cmd_valid cycles 1-3, cmd_id=0, req_done[0] at 4.
// T2 round-robin: req_valid=1111 held, ready=1 always -> grant order 0,1,2,3,0; cmd_valid low 1 cycle between each.
// T3 abort vs ready: cmd_abort and cmd_ready both high in cycle 2 -> req_abort[g] only; req_done stays 0.
// T4 watchdog: TIMEOUT=8, ready never -> cmd_valid high exactly 8 cycles, req_timeout[g] pulses, next requester is granted.
// T5 async reset asserted mid-ISSUE -> cmd_valid=0 immediately, rr_ptr=0; after release req_valid=0100 -> req_ready=0100.
// T6 ready on last watchdog cycle (TIMEOUT=4, ready at wdog=3) -> req_done pulses, req_timeout stays 0.

Source files
------------

// File: rtl/dma_cmd_arbiter.sv
// dma_cmd_arbiter: round-robin arbiter that shares one DMAC command port
// among NUM_REQ requester engines. A granted command is captured, held on
// cmd_* until the DMAC accepts or aborts it (or the watchdog drops it), and
// the outcome is returned to the originator as a one-cycle pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | scan requesters from rr_ptr, grant and capture the first valid
// ISSUE | command presented to DMAC, watchdog running
// GAP   | result pulse out, cmd_valid low, round-robin pointer advanced
module dma_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_ADDR_WD = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                           AXI_ACLK,
    input  logic                           AXI_ARESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WD-1:0] req_addr,
    input  logic [NUM_REQ*2-1:0]           req_burst,
    input  logic [NUM_REQ*3-1:0]           req_size,
    input  logic [NUM_REQ*AXI_ADDR_WD-1:0] req_len,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             req_abort,
    output logic [NUM_REQ-1:0]             req_timeout,
    output logic                           cmd_valid,
    output logic [AXI_ADDR_WD-1:0]         cmd_addr,
    output logic [AXI_ID_WD-1:0]           cmd_id,
    output logic [1:0]                     cmd_burst,
    output logic [2:0]                     cmd_size,
    output logic [AXI_ADDR_WD-1:0]         cmd_len,
    input  logic                           cmd_ready,
    input  logic                           cmd_abort
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Watchdog terminal count; unused when TIMEOUT is 0.
    localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [IDX_W:0]         cand;
    logic [WD_W-1:0]        wdog;
    logic                   wd_expire;
    logic [NUM_REQ-1:0]     grant_oh;
    logic                   take;
    logic                   done_set;
    logic                   abort_set;
    logic                   to_set;
    logic [AXI_ADDR_WD-1:0] sel_addr;
    logic [AXI_ADDR_WD-1:0] sel_len;
    logic [1:0]             sel_burst;
    logic [2:0]             sel_size;

    assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST);

    // Round-robin scan: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Select the winner's command fields out of the packed request buses.
    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_burst = '0;
        sel_size  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*AXI_ADDR_WD +: AXI_ADDR_WD];
                sel_len   = req_len[i*AXI_ADDR_WD +: AXI_ADDR_WD];
                sel_burst = req_burst[i*2 +: 2];
                sel_size  = req_size[i*3 +: 3];
            end
        end
    end

    // One-hot form of the current grant, used to route result pulses.
    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
    end

    // State register.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; any outcome in ISSUE leads to the single GAP cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_ISSUE;
            S_ISSUE: if (cmd_abort || cmd_ready || wd_expire) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: grant strobe in IDLE, prioritised outcome in ISSUE.
    always_comb begin
        req_ready = '0;
        take      = 1'b0;
        done_set  = 1'b0;
        abort_set = 1'b0;
        to_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    take               = 1'b1;
                    req_ready[win_idx] = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cmd_abort) begin
                    abort_set = 1'b1;
                end else if (cmd_ready) begin
                    done_set = 1'b1;
                end else if (wd_expire) begin
                    to_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Capture the granted command; fields hold their value until the next grant.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_burst <= '0;
            cmd_size  <= '0;
            cmd_id    <= '0;
            grant_idx <= '0;
        end else if (take) begin
            cmd_addr  <= sel_addr;
            cmd_len   <= sel_len;
            cmd_burst <= sel_burst;
            cmd_size  <= sel_size;
            cmd_id    <= AXI_ID_WD'(win_idx);
            grant_idx <= win_idx;
        end
    end

    // cmd_valid is registered and mirrors the ISSUE state.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= (state_nxt == S_ISSUE);
        end
    end

    // Watchdog counts ISSUE cycles from 0 and is cleared whenever ISSUE ends.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            wdog <= '0;
        end else if (state == S_ISSUE && state_nxt == S_ISSUE) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            rr_ptr <= '0;
        end else if (state == S_GAP) begin
            rr_ptr <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    // Result pulses, registered so they appear only during the GAP cycle.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            req_done    <= '0;
            req_abort   <= '0;
            req_timeout <= '0;
        end else begin
            req_done    <= done_set  ? grant_oh : '0;
            req_abort   <= abort_set ? grant_oh : '0;
            req_timeout <= to_set    ? grant_oh : '0;
        end
    end

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// tb_dma_cmd_arbiter: scoreboard bench for dma_cmd_arbiter. Two instances run
// on a shared clock/reset: instance 0 with an 8-cycle watchdog, instance 1
// with a 4-cycle watchdog. Stimulus pushes the expected outcome of each grant;
// the monitor pops and compares whenever an instance emits a result pulse.
module tb_dma_cmd_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_TO    = 2;

    typedef struct packed {
        int          dut;
        int          kind;
        int          idx;
        logic [31:0] addr;
        logic [31:0] len;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [NR-1:0]    req_valid   [2];
    logic [NR*AW-1:0] req_addr    [2];
    logic [NR*2-1:0]  req_burst   [2];
    logic [NR*3-1:0]  req_size    [2];
    logic [NR*AW-1:0] req_len     [2];
    logic [NR-1:0]    req_ready   [2];
    logic [NR-1:0]    req_done    [2];
    logic [NR-1:0]    req_abort   [2];
    logic [NR-1:0]    req_timeout [2];
    logic             cmd_valid   [2];
    logic [AW-1:0]    cmd_addr    [2];
    logic [1:0]       cmd_id      [2];
    logic [1:0]       cmd_burst   [2];
    logic [2:0]       cmd_size    [2];
    logic [AW-1:0]    cmd_len     [2];
    logic             cmd_ready   [2];
    logic             cmd_abort   [2];

    logic [31:0] tbl_addr  [4] = '{32'h0000_1000, 32'h0000_2040, 32'h0003_00A0, 32'h8000_4FFC};
    logic [31:0] tbl_len   [4] = '{32'd64, 32'd128, 32'd7, 32'hFFFF_FFFF};
    logic [1:0]  tbl_burst [4] = '{2'd1, 2'd0, 2'd2, 2'd3};
    logic [2:0]  tbl_size  [4] = '{3'd2, 3'd0, 3'd5, 3'd7};

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        prev_v   [2];
    int          vcnt     [2];
    logic [3:0]  rdy_seen [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dma_cmd_arbiter #(
            .NUM_REQ(NR), .AXI_ID_WD(2), .AXI_ADDR_WD(AW), .TIMEOUT(g == 0 ? 8 : 4)
        ) u_dut (
            .AXI_ACLK   (clk),
            .AXI_ARESET (rst),
            .req_valid  (req_valid[g]),
            .req_addr   (req_addr[g]),
            .req_burst  (req_burst[g]),
            .req_size   (req_size[g]),
            .req_len    (req_len[g]),
            .req_ready  (req_ready[g]),
            .req_done   (req_done[g]),
            .req_abort  (req_abort[g]),
            .req_timeout(req_timeout[g]),
            .cmd_valid  (cmd_valid[g]),
            .cmd_addr   (cmd_addr[g]),
            .cmd_id     (cmd_id[g]),
            .cmd_burst  (cmd_burst[g]),
            .cmd_size   (cmd_size[g]),
            .cmd_len    (cmd_len[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_abort  (cmd_abort[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_fields(input int k);
        for (int i = 0; i < NR; i++) begin
            req_addr[k][i*AW +: AW] = tbl_addr[i];
            req_len[k][i*AW +: AW]  = tbl_len[i];
            req_burst[k][i*2 +: 2]  = tbl_burst[i];
            req_size[k][i*3 +: 3]   = tbl_size[i];
        end
    endtask

    task automatic push(input int dut, input int kind, input int idx, input int vcyc);
        exp_t e;
        e.dut   = dut;
        e.kind  = kind;
        e.idx   = idx;
        e.addr  = tbl_addr[idx];
        e.len   = tbl_len[idx];
        e.burst = tbl_burst[idx];
        e.size  = tbl_size[idx];
        e.vcyc  = vcyc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input int k);
        chk($sformatf("rst_cmd_valid%0d", k), 64'(cmd_valid[k]), 0);
        chk($sformatf("rst_cmd_addr%0d", k), 64'(cmd_addr[k]), 0);
        chk($sformatf("rst_cmd_id%0d", k), 64'(cmd_id[k]), 0);
        chk($sformatf("rst_cmd_len%0d", k), 64'(cmd_len[k]), 0);
        chk($sformatf("rst_results%0d", k), 64'({req_done[k], req_abort[k], req_timeout[k]}), 0);
    endtask

    task automatic check_result(input int k);
        exp_t       e;
        int         kind;
        int         nres;
        logic [3:0] vec;
        nres = int'(req_done[k] != '0) + int'(req_abort[k] != '0) + int'(req_timeout[k] != '0);
        chk($sformatf("one_result%0d", k), 64'(nres), 1);
        if (req_done[k] != '0) begin
            kind = K_DONE;
            vec  = req_done[k];
        end else if (req_abort[k] != '0) begin
            kind = K_ABORT;
            vec  = req_abort[k];
        end else begin
            kind = K_TO;
            vec  = req_timeout[k];
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result dut%0d @%0t: got kind %0d vec %b, expected no result",
                     k, $time, kind, vec);
        end else begin
            e = exp_q.pop_front();
            chk("result_dut", 64'(k), 64'(e.dut));
            chk($sformatf("kind%0d", k), 64'(kind), 64'(e.kind));
            chk($sformatf("pulse_vec%0d", k), 64'(vec), 64'(1 << e.idx));
            chk($sformatf("grant_ready%0d", k), 64'(rdy_seen[k]), 64'(1 << e.idx));
            chk($sformatf("cmd_id%0d", k), 64'(cmd_id[k]), 64'(e.idx));
            chk($sformatf("cmd_addr%0d", k), 64'(cmd_addr[k]), 64'(e.addr));
            chk($sformatf("cmd_len%0d", k), 64'(cmd_len[k]), 64'(e.len));
            chk($sformatf("cmd_burst%0d", k), 64'(cmd_burst[k]), 64'(e.burst));
            chk($sformatf("cmd_size%0d", k), 64'(cmd_size[k]), 64'(e.size));
            chk($sformatf("valid_cycles%0d", k), 64'(vcnt[k]), 64'(e.vcyc));
            chk($sformatf("gap_valid%0d", k), 64'(cmd_valid[k]), 0);
        end
        rdy_seen[k] = '0;
    endtask

    // Monitor: tracks grant strobes and cmd_valid run length, checks each result.
    initial begin
        for (int k = 0; k < 2; k++) begin
            prev_v[k]   = 1'b0;
            vcnt[k]     = 0;
            rdy_seen[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    prev_v[k]   = 1'b0;
                    vcnt[k]     = 0;
                    rdy_seen[k] = '0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (req_ready[k] != '0) begin
                        chk($sformatf("ready_onehot%0d", k), 64'($onehot(req_ready[k])), 1);
                        rdy_seen[k] = req_ready[k];
                    end
                    if (cmd_valid[k]) begin
                        vcnt[k] = prev_v[k] ? vcnt[k] + 1 : 1;
                    end
                    prev_v[k] = cmd_valid[k];
                    if ((req_done[k] | req_abort[k] | req_timeout[k]) != '0) begin
                        check_result(k);
                    end
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "time limit reached");
    end

    // Directed stimulus; cycle numbers in comments are relative to each test's cycle 0.
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0;
            cmd_ready[k] = 1'b0;
            cmd_abort[k] = 1'b0;
            load_fields(k);
        end
        tick(1);
        check_reset_state(0);
        check_reset_state(1);
        chk("rst_req_ready0", 64'(req_ready[0]), 0);
        tick(1);
        rst = 1'b0;

        // T1: single command from requester 0, accepted in cycle 3
        push(0, K_DONE, 0, 3);
        req_valid[0] = 4'b0001;
        tick(1);                                  // c1
        req_valid[0] = 4'b0000;
        req_addr[0][31:0] = 32'hDEAD_BEEF;        // must not disturb the captured command
        tick(2);                                  // c3
        cmd_ready[0] = 1'b1;
        tick(1);                                  // c4: GAP, done pulse
        cmd_ready[0] = 1'b0;
        load_fields(0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // T2: all four requesting, DMAC always ready -> 0,1,2,3,0
        push(0, K_DONE, 0, 1);
        push(0, K_DONE, 1, 1);
        push(0, K_DONE, 2, 1);
        push(0, K_DONE, 3, 1);
        push(0, K_DONE, 0, 1);
        req_valid[0] = 4'b1111;
        cmd_ready[0] = 1'b1;
        tick(13);                                 // c13: ISSUE of fifth grant
        req_valid[0] = 4'b0000;
        tick(1);
        cmd_ready[0] = 1'b0;
        tick(2);

        // T3: abort and ready together in cycle 2 -> abort only (rr_ptr=1)
        push(0, K_ABORT, 2, 2);
        req_valid[0] = 4'b0100;
        tick(1);
        req_valid[0] = 4'b0000;
        tick(1);                                  // c2
        cmd_abort[0] = 1'b1;
        cmd_ready[0] = 1'b1;
        tick(1);
        cmd_abort[0] = 1'b0;
        cmd_ready[0] = 1'b0;
        tick(1);

        // T3b: rr_ptr=3 with 1 and 3 valid -> 3 (aborted), then wrap to 1 (done)
        push(0, K_ABORT, 3, 1);
        push(0, K_DONE, 1, 1);
        req_valid[0] = 4'b1010;
        tick(1);                                  // c1
        req_valid[0] = 4'b0010;
        cmd_abort[0] = 1'b1;
        tick(1);
        cmd_abort[0] = 1'b0;
        tick(2);                                  // c4: ISSUE of requester 1
        req_valid[0] = 4'b0000;
        cmd_ready[0] = 1'b1;
        tick(1);
        cmd_ready[0] = 1'b0;
        tick(1);

        // T4: watchdog of 8 drops requester 0, requester 1 is granted next (rr_ptr=2)
        push(0, K_TO, 0, 8);
        push(0, K_DONE, 1, 1);
        req_valid[0] = 4'b0011;
        tick(1);                                  // c1
        req_valid[0] = 4'b0010;
        tick(10);                                 // c11: ISSUE of requester 1
        req_valid[0] = 4'b0000;
        cmd_ready[0] = 1'b1;
        tick(1);
        cmd_ready[0] = 1'b0;
        tick(1);

        // T5: async reset during ISSUE of requester 3, then rr_ptr must restart at 0
        req_valid[0] = 4'b1000;
        tick(1);
        req_valid[0] = 4'b0000;
        tick(1);                                  // c2: in ISSUE
        rst = 1'b1;
        #1;
        chk("midrst_cmd_valid", 64'(cmd_valid[0]), 0);
        chk("midrst_cmd_addr", 64'(cmd_addr[0]), 0);
        chk("midrst_cmd_id", 64'(cmd_id[0]), 0);
        tick(1);
        chk("midrst_no_result", 64'({req_done[0], req_abort[0], req_timeout[0]}), 0);
        rst = 1'b0;
        push(0, K_DONE, 1, 2);
        req_valid[0] = 4'b0110;
        tick(1);
        req_valid[0] = 4'b0000;
        tick(1);                                  // c2
        cmd_ready[0] = 1'b1;
        tick(1);
        cmd_ready[0] = 1'b0;
        tick(1);

        // T6: watchdog of 4, ready on the last watchdog cycle -> done; then a plain timeout
        push(1, K_DONE, 0, 4);
        push(1, K_TO, 1, 4);
        req_valid[1] = 4'b0011;
        tick(1);                                  // c1
        req_valid[1] = 4'b0010;
        tick(3);                                  // c4: wdog=3
        cmd_ready[1] = 1'b1;
        tick(1);
        cmd_ready[1] = 1'b0;
        tick(2);                                  // c7: ISSUE of requester 1
        req_valid[1] = 4'b0000;
        tick(6);

        tick(2);
        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
